combo_lock_ctrl: RTL and testbench

- Sequencing controller for the combination lock. Consumes one-cycle pulses from the per-button debouncers and collects a digit sequence.
- Compares the sequence against the stored code. Drives unlock, auto-relock, failed-attempt counting and alarm lockout.
- Sits between the debouncer bank and the LED/lock-output logic. All logic runs on the 100 MHz system clock.

---
 rtl/combo_lock_ctrl.sv | 135 +++++++++++++
 tb/tb_combo_lock_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: digit-sequence combination lock with auto-relock, failed-attempt lockout and
// optional in-field code programming (enabled by defining COMBO_PROG_CODE_EN).
module combo_lock_ctrl #(
  parameter int CODE_LEN = 4,
  parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 8'b11_10_01_00,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 100000000,
  parameter int RELOCK_CYCLES = 500000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN_PULSE,
  input  logic       LOCK_PULSE,
  input  logic       SET_PULSE,
  output logic       UNLOCKED,
  output logic       ALARM,
  output logic [1:0] STATE,
  output logic [2:0] DIGIT_CNT,
  output logic [1:0] FAIL_CNT
);
  localparam int TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int TW = $clog2(TMAX);
  typedef enum logic [1:0] {LOCKED, OPEN, LOCKOUT, PROG} state_t;
  state_t st;
  logic [TW-1:0] timer;
  logic mis, single, bad, last;
  logic [1:0] dval, cdig, fail_nx;
  logic [2*CODE_LEN-1:0] code;
  assign STATE = st;
  assign single = (|BTN_PULSE) && ~|(BTN_PULSE & (BTN_PULSE - 4'd1));
  assign dval = {BTN_PULSE[3] | BTN_PULSE[2], BTN_PULSE[3] | BTN_PULSE[1]};
  assign cdig = code[{DIGIT_CNT, 1'b0} +: 2];
  assign bad = !single || dval != cdig;
  assign last = DIGIT_CNT == 3'(CODE_LEN - 1);
  assign fail_nx = FAIL_CNT + 2'd1;
`ifdef COMBO_PROG_CODE_EN
  // new digits collect in a shadow so an aborted programming session leaves the code intact
  logic [2*CODE_LEN-1:0] shadow, shadow_nx;
  always_comb begin
    shadow_nx = shadow;
    shadow_nx[{DIGIT_CNT, 1'b0} +: 2] = dval;
  end
`else
  logic unused_set;
  assign code = DEFAULT_CODE;
  assign unused_set = SET_PULSE;
`endif
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      st <= LOCKED;
      UNLOCKED <= 1'b0;
      ALARM <= 1'b0;
      DIGIT_CNT <= 3'd0;
      FAIL_CNT <= 2'd0;
      mis <= 1'b0;
      timer <= '0;
`ifdef COMBO_PROG_CODE_EN
      code <= DEFAULT_CODE;
      shadow <= DEFAULT_CODE;
`endif
    end else
      case (st)
        LOCKED:
          if (LOCK_PULSE) begin
            DIGIT_CNT <= 3'd0;
            mis <= 1'b0;
          end else if (|BTN_PULSE) begin
            if (!last) begin
              DIGIT_CNT <= DIGIT_CNT + 3'd1;
              mis <= mis | bad;
            end else begin
              DIGIT_CNT <= 3'd0;
              mis <= 1'b0;
              timer <= '0;
              if (mis | bad) begin
                FAIL_CNT <= fail_nx;
                if (fail_nx == 2'(MAX_FAILS)) begin
                  st <= LOCKOUT;
                  ALARM <= 1'b1;
                end
              end else begin
                st <= OPEN;
                UNLOCKED <= 1'b1;
                FAIL_CNT <= 2'd0;
              end
            end
          end
        OPEN:
          if (LOCK_PULSE || timer == TW'(RELOCK_CYCLES - 1)) begin
            st <= LOCKED;
            UNLOCKED <= 1'b0;
            timer <= '0;
          end
`ifdef COMBO_PROG_CODE_EN
          else if (SET_PULSE) begin
            st <= PROG;
            DIGIT_CNT <= 3'd0;
            timer <= '0;
            shadow <= code;
          end
`endif
          else timer <= timer + 1'b1;
        LOCKOUT:
          if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
            st <= LOCKED;
            ALARM <= 1'b0;
            FAIL_CNT <= 2'd0;
            timer <= '0;
          end else timer <= timer + 1'b1;
`ifdef COMBO_PROG_CODE_EN
        PROG:
          if (LOCK_PULSE) begin
            st <= LOCKED;
            UNLOCKED <= 1'b0;
            DIGIT_CNT <= 3'd0;
          end else if (single) begin
            shadow <= shadow_nx;
            DIGIT_CNT <= last ? 3'd0 : DIGIT_CNT + 3'd1;
            if (last) begin
              code <= shadow_nx;
              st <= OPEN;
              timer <= '0;
            end
          end
`endif
        default: begin
          st <= LOCKED;
          UNLOCKED <= 1'b0;
          ALARM <= 1'b0;
          DIGIT_CNT <= 3'd0;
          mis <= 1'b0;
          timer <= '0;
        end
      endcase
endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: vector table, hand-written corner sequences and randomized traffic
// against a queue-based behavioural model of the lock.
module tb_combo_lock_ctrl;
`ifdef COMBO_PROG_CODE_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif
  logic CLK = 1'b0, RST_N = 1'b0, LOCK_PULSE = 1'b0, SET_PULSE = 1'b0;
  logic [3:0] BTN_PULSE = 4'd0;
  logic UNLOCKED, ALARM;
  logic [1:0] STATE, FAIL_CNT;
  logic [2:0] DIGIT_CNT;
  logic [8:0] dout;
  int n_tests = 0, n_fail = 0;

  combo_lock_ctrl #(.CODE_LEN(4), .DEFAULT_CODE(8'b11_10_01_00), .MAX_FAILS(3),
                    .LOCKOUT_CYCLES(20), .RELOCK_CYCLES(50)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_PULSE(BTN_PULSE), .LOCK_PULSE(LOCK_PULSE),
    .SET_PULSE(SET_PULSE), .UNLOCKED(UNLOCKED), .ALARM(ALARM), .STATE(STATE),
    .DIGIT_CNT(DIGIT_CNT), .FAIL_CNT(FAIL_CNT));

  always #5 CLK = ~CLK;
  assign dout = {UNLOCKED, ALARM, STATE, DIGIT_CNT, FAIL_CNT};

  // model: 0 locked, 1 open, 2 lockout, 3 programming; entries kept as digit lists
  int m_state, m_fail, m_timer;
  int m_entry[$], m_prog[$];
  int m_code[4];

  function automatic logic [8:0] o(int u, int a, int s, int d, int f);
    return {1'(u), 1'(a), 2'(s), 3'(d), 2'(f)};
  endfunction

  function automatic int decode(logic [3:0] b);
    if ($countones(b) != 1) return -1;
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return -1;
  endfunction

  function automatic logic [8:0] model_out();
    int d;
    d = m_state == 0 ? m_entry.size() : m_state == 3 ? m_prog.size() : 0;
    return o(int'(m_state == 1 || m_state == 3), int'(m_state == 2), m_state, d, m_fail);
  endfunction

  task automatic model_reset();
    m_state = 0; m_fail = 0; m_timer = 0;
    m_entry.delete(); m_prog.delete();
    m_code = '{0, 1, 2, 3};
  endtask

  task automatic model_step(input logic [3:0] b, input logic l, input logic s);
    bit ok;
    case (m_state)
      0: if (l) m_entry.delete();
         else if (b != 0) begin
           m_entry.push_back(decode(b));
           if (m_entry.size() == 4) begin
             ok = 1;
             for (int i = 0; i < 4; i++) if (m_entry[i] != m_code[i]) ok = 0;
             m_entry.delete();
             m_timer = 0;
             if (ok) begin m_state = 1; m_fail = 0; end
             else begin m_fail++; if (m_fail == 3) m_state = 2; end
           end
         end
      1: if (l || m_timer == 49) begin m_state = 0; m_timer = 0; end
         else if (PROG_EN && s) begin m_state = 3; m_timer = 0; m_prog.delete(); end
         else m_timer++;
      2: if (m_timer == 19) begin m_state = 0; m_fail = 0; m_timer = 0; end
         else m_timer++;
      default: if (l) begin m_state = 0; m_prog.delete(); end
         else if (decode(b) >= 0) begin
           m_prog.push_back(decode(b));
           if (m_prog.size() == 4) begin
             for (int i = 0; i < 4; i++) m_code[i] = m_prog[i];
             m_prog.delete();
             m_state = 1;
             m_timer = 0;
           end
         end
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // called at a falling edge; applies one cycle of input and checks against the model
  task automatic cyc(input logic [3:0] b, input logic l, input logic s);
    BTN_PULSE = b; LOCK_PULSE = l; SET_PULSE = s;
    @(posedge CLK);
    model_step(b, l, s);
    @(negedge CLK);
    BTN_PULSE = 4'd0; LOCK_PULSE = 1'b0; SET_PULSE = 1'b0;
    check("model", int'(dout), int'(model_out()));
  endtask

  task automatic press(input logic [3:0] b);
    cyc(b, 1'b0, 1'b0);
    repeat (4) cyc(4'd0, 1'b0, 1'b0);
  endtask

  task automatic unlock();
    press(4'd1); press(4'd2); press(4'd4); cyc(4'd8, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #1 RST_N = 1'b0;
    #1 model_reset();
    @(negedge CLK) RST_N = 1'b1;
  endtask

  typedef struct { logic [3:0] btn; logic lk; logic [8:0] exp; } vec_t;
  vec_t tbl[$];

  initial begin
    int n;
    logic [3:0] b;
    tbl.push_back('{4'd1, 1'b0, o(0,0,0,1,0)});
    tbl.push_back('{4'd2, 1'b0, o(0,0,0,2,0)});
    tbl.push_back('{4'd4, 1'b1, o(0,0,0,0,0)});
    tbl.push_back('{4'd1, 1'b0, o(0,0,0,1,0)});
    tbl.push_back('{4'd2, 1'b0, o(0,0,0,2,0)});
    tbl.push_back('{4'd4, 1'b0, o(0,0,0,3,0)});
    tbl.push_back('{4'd8, 1'b0, o(1,0,1,0,0)});
    tbl.push_back('{4'd0, 1'b1, o(0,0,0,0,0)});
    tbl.push_back('{4'd3, 1'b0, o(0,0,0,1,0)});
    tbl.push_back('{4'd2, 1'b0, o(0,0,0,2,0)});
    tbl.push_back('{4'd4, 1'b0, o(0,0,0,3,0)});
    tbl.push_back('{4'd8, 1'b0, o(0,0,0,0,1)});
    tbl.push_back('{4'd1, 1'b0, o(0,0,0,1,1)});
    tbl.push_back('{4'd1, 1'b0, o(0,0,0,2,1)});
    tbl.push_back('{4'd1, 1'b0, o(0,0,0,3,1)});
    tbl.push_back('{4'd1, 1'b0, o(0,0,0,0,2)});
    tbl.push_back('{4'd1, 1'b0, o(0,0,0,1,2)});
    tbl.push_back('{4'd1, 1'b0, o(0,0,0,2,2)});
    tbl.push_back('{4'd1, 1'b0, o(0,0,0,3,2)});
    tbl.push_back('{4'd1, 1'b0, o(0,1,2,0,3)});
    model_reset();
    #2 check("reset", int'(dout), 0);
    @(negedge CLK) RST_N = 1'b1;
    foreach (tbl[i]) begin
      cyc(tbl[i].btn, tbl[i].lk, 1'b0);
      check($sformatf("vec%0d", i), int'(dout), int'(tbl[i].exp));
    end
    // lockout ignores every pulse and lasts exactly 20 cycles
    for (int i = 0; i < 19; i++) cyc(4'(1 << (i % 4)), 1'(i % 5 == 0), 1'b0);
    check("lockout_hold", int'(dout), int'(o(0,1,2,0,3)));
    cyc(4'd0, 1'b0, 1'b0);
    check("lockout_end", int'(dout), int'(o(0,0,0,0,0)));
    repeat (3) cyc(4'd0, 1'b0, 1'b0);
    unlock();
    check("unlock_after_lockout", int'(dout), int'(o(1,0,1,0,0)));
    n = 0;
    while (UNLOCKED && n < 100) begin cyc(4'd0, 1'b0, 1'b0); n++; end
    check("relock_time", n, 50);
    unlock();
    repeat (9) cyc(4'd0, 1'b0, 1'b0);
    check("still_open", int'(UNLOCKED), 1);
    cyc(4'd0, 1'b1, 1'b0);
    check("manual_lock", int'(dout), int'(o(0,0,0,0,0)));
    repeat (12) cyc(4'd1, 1'b0, 1'b0);
    check("lockout_again", int'(dout), int'(o(0,1,2,0,3)));
    repeat (7) cyc(4'd0, 1'b0, 1'b0);
    #1 RST_N = 1'b0;
    #1 check("async_reset", int'(dout), 0);
    model_reset();
    @(negedge CLK) RST_N = 1'b1;
    cyc(4'd0, 1'b0, 1'b0);
    check("after_reset", int'(dout), 0);
`ifdef COMBO_PROG_CODE_EN
    unlock();
    cyc(4'd0, 1'b0, 1'b1);
    check("prog_enter", int'(dout), int'(o(1,0,3,0,0)));
    cyc(4'd8, 1'b0, 1'b0); cyc(4'd8, 1'b0, 1'b0); cyc(4'd4, 1'b0, 1'b0); cyc(4'd4, 1'b0, 1'b0);
    check("prog_commit", int'(STATE), 1);
    cyc(4'd0, 1'b1, 1'b0);
    cyc(4'd8, 1'b0, 1'b0); cyc(4'd8, 1'b0, 1'b0); cyc(4'd4, 1'b0, 1'b0); cyc(4'd4, 1'b0, 1'b0);
    check("new_code", int'(STATE), 1);
    cyc(4'd0, 1'b1, 1'b0);
    unlock();
    check("old_code_rejected", int'(dout), int'(o(0,0,0,0,1)));
    do_reset();
    unlock();
    cyc(4'd0, 1'b0, 1'b1);
    cyc(4'd8, 1'b0, 1'b0); cyc(4'd8, 1'b0, 1'b0);
    cyc(4'd0, 1'b1, 1'b0);
    check("prog_abort", int'(dout), int'(o(0,0,0,0,0)));
    unlock();
    check("code_kept", int'(STATE), 1);
    cyc(4'd0, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 3000; i++) begin
      n = int'($urandom_range(99));
      if (n < 55) b = 4'd0;
      else if (n < 85) b = 4'(1 << (m_state == 0 && $urandom_range(9) < 7 ?
                                    m_code[m_entry.size()] : $urandom_range(3)));
      else b = 4'($urandom_range(15));
      cyc(b, 1'($urandom_range(99) < 3), 1'($urandom_range(99) < 4));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
